// File: rtl/fetch_pkg.sv
// fetch_pkg: sequencer state type and default geometry shared by the fetch controller.
`default_nettype none

package fetch_pkg;

   localparam int PC_W_DEF       = 10;
   localparam int START_ADDR_DEF = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection (Halt > Stall > BranchAbs > BranchRel > PC+1).
`default_nettype none

module pc_next #(
   parameter int PC_W = 10
) (
   input  logic            halt,
   input  logic            stall,
   input  logic            branch_abs,
   input  logic            branch_rel,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] target,
   input  logic [7:0]      offset,
   output logic [PC_W-1:0] next_pc
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   // Sign-extend into a word wider than the PC, then keep the low PC_W bits
   // so the addition wraps modulo 2^PC_W for any PC_W.
   logic [PC_W+7:0] offset_wide;
   assign offset_wide = {{PC_W{offset[7]}}, offset};

   always_comb begin
      next_pc = pc + PC_ONE;
      if (halt || stall)
         next_pc = pc;
      else if (branch_abs)
         next_pc = target;
      else if (branch_rel)
         next_pc = pc + offset_wide[PC_W-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IDLE/RUN/DONE program sequencer driving the instruction ROM address.
// Optional RUN-cycle counter enabled by macro FETCH_CYCLE_COUNT_EN.
`default_nettype none

module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int PC_W       = PC_W_DEF,
   parameter int START_ADDR = START_ADDR_DEF
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   input  logic            Stall,
   input  logic            Halt,
   input  logic            BranchAbs,
   input  logic            BranchRel,
   input  logic [PC_W-1:0] Target,
   input  logic [7:0]      Offset,
   output logic [PC_W-1:0] ProgCtr,
   output logic            Busy,
   output logic            Done,
   output logic [15:0]     CycleCount
);

   localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];

   state_t          state;
   logic [PC_W-1:0] next_pc;

   pc_next #(
      .PC_W (PC_W)
   ) u_pc_next (
      .halt       (Halt),
      .stall      (Stall),
      .branch_abs (BranchAbs),
      .branch_rel (BranchRel),
      .pc         (ProgCtr),
      .target     (Target),
      .offset     (Offset),
      .next_pc    (next_pc)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         ProgCtr <= START_PC;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  state   <= ST_RUN;
                  ProgCtr <= START_PC;
               end
            end
            ST_RUN: begin
               ProgCtr <= next_pc;
               if (Halt)
                  state <= ST_DONE;
            end
            default: begin
               state   <= ST_IDLE;
               ProgCtr <= START_PC;
            end
         endcase
      end
   end

   assign Busy = (state == ST_RUN);
   assign Done = (state == ST_DONE);

`ifdef FETCH_CYCLE_COUNT_EN
   logic [15:0] cycle_cnt;

   // Counts stalled cycles too; saturates rather than wrapping.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         cycle_cnt <= 16'd0;
      else if ((state != ST_RUN) && Start)
         cycle_cnt <= 16'd0;
      else if ((state == ST_RUN) && (cycle_cnt != 16'hFFFF))
         cycle_cnt <= cycle_cnt + 16'd1;
   end

   assign CycleCount = cycle_cnt;
`else
   assign CycleCount = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
`default_nettype none

module tb_fetch_ctrl;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       Stall;
   logic       Halt;
   logic       BranchAbs;
   logic       BranchRel;
   logic [9:0] Target;
   logic [7:0] Offset;
   logic [9:0] ProgCtr;
   logic       Busy;
   logic       Done;
   logic [15:0] CycleCount;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef FETCH_CYCLE_COUNT_EN
   localparam bit CC_EN = 1'b1;
`else
   localparam bit CC_EN = 1'b0;
`endif

   fetch_ctrl #(.PC_W(10), .START_ADDR(0)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .Stall      (Stall),
      .Halt       (Halt),
      .BranchAbs  (BranchAbs),
      .BranchRel  (BranchRel),
      .Target     (Target),
      .Offset     (Offset),
      .ProgCtr    (ProgCtr),
      .Busy       (Busy),
      .Done       (Done),
      .CycleCount (CycleCount)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_pc(input string name, input logic [9:0] exp);
      n_cmp++;
      if (ProgCtr !== exp) begin
         n_bad++;
         $display("FAIL %s: ProgCtr got %0d expected %0d", name, ProgCtr, exp);
      end
   endtask

   task automatic chk_st(input string name, input logic exp_busy, input logic exp_done);
      n_cmp++;
      if (Busy !== exp_busy || Done !== exp_done) begin
         n_bad++;
         $display("FAIL %s: Busy/Done got %b/%b expected %b/%b", name, Busy, Done, exp_busy, exp_done);
      end
   endtask

   task automatic chk_cc(input string name, input logic [15:0] exp_on);
      logic [15:0] exp;
      exp = CC_EN ? exp_on : 16'd0;
      n_cmp++;
      if (CycleCount !== exp) begin
         n_bad++;
         $display("FAIL %s: CycleCount got %0d expected %0d", name, CycleCount, exp);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Halt = 1'b0;
      BranchAbs = 1'b0; BranchRel = 1'b0; Target = '0; Offset = '0;
      #1;
      chk_pc("reset_pc", 10'd0);
      chk_st("reset_state", 1'b0, 1'b0);
      chk_cc("reset_cc", 16'd0);
      step();
      Reset = 1'b0;
      // Controls other than Start are ignored while idle.
      BranchAbs = 1'b1; Target = 10'd5; Halt = 1'b1;
      step();
      chk_pc("idle_ignores_branch", 10'd0);
      chk_st("idle_stays_idle", 1'b0, 1'b0);
      BranchAbs = 1'b0; Halt = 1'b0;
   endtask

   task automatic test_plain();
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk_pc("start_pc", 10'd0);
      chk_st("start_busy", 1'b1, 1'b0);
      chk_cc("start_cc", 16'd0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_pc("plain_step", 10'(i));
      end
      chk_st("plain_busy", 1'b1, 1'b0);
      chk_cc("plain_cc", 16'd5);
   endtask

   task automatic test_branch();
      BranchAbs = 1'b1; Target = 10'd10;
      step();
      chk_pc("abs_to_10", 10'd10);
      BranchAbs = 1'b0; BranchRel = 1'b1; Offset = 8'hFD;
      step();
      chk_pc("rel_minus3", 10'd7);
      BranchRel = 1'b0; BranchAbs = 1'b1; Target = 10'd2;
      step();
      chk_pc("abs_to_2", 10'd2);
      BranchAbs = 1'b0; BranchRel = 1'b1; Offset = 8'hFB;
      step();
      chk_pc("rel_wrap_1021", 10'd1021);
      BranchRel = 1'b0; BranchAbs = 1'b1; Target = 10'd1023;
      step();
      chk_pc("abs_to_1023", 10'd1023);
      BranchAbs = 1'b0;
      step();
      chk_pc("inc_wrap_0", 10'd0);
   endtask

   task automatic test_priority();
      BranchAbs = 1'b1; Target = 10'd300; BranchRel = 1'b1; Offset = 8'd4; Stall = 1'b1;
      step();
      chk_pc("stall_holds", 10'd0);
      chk_st("stall_busy", 1'b1, 1'b0);
      Stall = 1'b0;
      step();
      chk_pc("abs_over_rel", 10'd300);
      BranchAbs = 1'b0; BranchRel = 1'b0;
   endtask

   task automatic test_halt();
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk_pc("start_ignored_in_run", 10'd301);
      BranchAbs = 1'b1; Target = 10'd50;
      step();
      BranchAbs = 1'b0;
      chk_pc("abs_to_50", 10'd50);
      Halt = 1'b1;
      step();
      chk_pc("halt_holds_pc", 10'd50);
      chk_st("halt_done", 1'b0, 1'b1);
      chk_cc("halt_cc", 16'd16);
      Stall = 1'b1; BranchAbs = 1'b1; Target = 10'd7;
      step();
      Stall = 1'b0; BranchAbs = 1'b0; Halt = 1'b0;
      chk_pc("done_ignores_ctrl", 10'd50);
      chk_st("done_stays", 1'b0, 1'b1);
      chk_cc("done_cc_hold", 16'd16);
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk_pc("restart_pc", 10'd0);
      chk_st("restart_busy", 1'b1, 1'b0);
      chk_cc("restart_cc_clear", 16'd0);
      step();
      chk_pc("restart_step", 10'd1);
      chk_cc("restart_cc_count", 16'd1);
   endtask

   task automatic test_reset_midrun();
      for (int i = 0; i < 36; i++)
         step();
      chk_pc("reach_37", 10'd37);
      #2;
      Reset = 1'b1;
      #1;
      chk_pc("async_reset_pc", 10'd0);
      chk_st("async_reset_state", 1'b0, 1'b0);
      chk_cc("async_reset_cc", 16'd0);
      step();
      Reset = 1'b0;
      step();
      step();
      chk_pc("post_reset_pc", 10'd0);
      chk_st("post_reset_idle", 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_plain();
      test_branch();
      test_priority();
      test_halt();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program counter / instruction address width (1024-entry instruction ROM).
REQ-002 SHALL have parameter START_ADDR, default 0, meaning the PC value loaded on each Start.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  level/pulse request to begin program execution.
REQ-006 SHALL have port Stall  input  1  holds PC for the current cycle.
REQ-007 SHALL have port Halt  input  1  decoded halt instruction at the current PC.
REQ-008 SHALL have port BranchAbs  input  1  absolute-jump request.
REQ-009 SHALL have port BranchRel  input  1  PC-relative branch request (taken).
REQ-010 SHALL have port Target  input  PC_W  absolute jump address.
REQ-011 SHALL have port Offset  input  8  signed two's-complement relative offset.
REQ-012 SHALL have port ProgCtr  output  PC_W  instruction address, driven to the instruction ROM InstAddress.
REQ-013 SHALL have port Busy  output  1  high while in RUN.
REQ-014 SHALL have port Done  output  1  high while in DONE.
REQ-015 SHALL have port CycleCount  output  16  RUN-cycle count (see Configuration).

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; encoding is free.
REQ-017 SHALL, in IDLE or DONE with Start=1, load ProgCtr=START_ADDR and enter RUN on the next edge.
REQ-018 SHALL ignore Start while in RUN.
REQ-019 SHALL, in RUN, select the next PC by priority: Halt > Stall > BranchAbs > BranchRel > ProgCtr+1.
REQ-020 SHALL, on Halt in RUN, enter DONE and hold ProgCtr unchanged.
REQ-021 SHALL, on Stall in RUN without Halt, hold ProgCtr and state.
REQ-022 SHALL, on BranchAbs, load ProgCtr=Target.
REQ-023 SHALL, on BranchRel only, load ProgCtr=(ProgCtr + sign-extended Offset) mod 2^PC_W.
REQ-024 SHALL wrap sequential increment from 2^PC_W-1 to 0.
REQ-025 SHALL ignore Halt, Stall, BranchAbs and BranchRel outside RUN.
REQ-026 SHALL drive Busy and Done combinationally from state only; they are never both high.
REQ-027 SHALL keep Done high in DONE until the Start edge that re-enters RUN.
REQ-028 SHALL deliver the new ProgCtr one cycle after the decision edge; ROM data follows combinationally in the same cycle.

Reset
REQ-029 SHALL, on Reset=1 asynchronously, force state=IDLE, ProgCtr=START_ADDR, Busy=0, Done=0, CycleCount=0.
REQ-030 SHALL abort any in-flight RUN on Reset, with no further PC update until Reset deasserts and Start is seen.

Configuration
REQ-031 SHALL honor macro FETCH_CYCLE_COUNT_EN.
REQ-032 SHALL, with FETCH_CYCLE_COUNT_EN defined, count every RUN cycle (stalled cycles included), saturate at 16'hFFFF, clear on each Start accepted in IDLE/DONE, and hold its value in DONE.
REQ-033 SHALL, without FETCH_CYCLE_COUNT_EN, tie CycleCount to 0 and synthesize no counter flops.

Structure
REQ-034 SHALL place the state enum typedef and the default PC_W/START_ADDR constants in shared package fetch_pkg.
REQ-035 SHALL isolate the combinational next-PC priority mux and adder in sub-module pc_next; registers stay in fetch_ctrl.

Verification
REQ-036 SHALL cover: Reset mid-RUN at ProgCtr=37 -> same cycle ProgCtr=0, Busy=0; stays IDLE after release.
REQ-037 SHALL cover: Start, 5 plain cycles -> ProgCtr 0,1,2,3,4,5; Busy=1; CycleCount=5 with macro, 0 without.
REQ-038 SHALL cover: ProgCtr=10, BranchRel=1, Offset=-3 -> 7; ProgCtr=2, Offset=-5 -> 1021; ProgCtr=1023, plain step -> 0.
REQ-039 SHALL cover: BranchAbs=1 with Target=300, BranchRel=1 with Offset=4, and Stall=1 together -> ProgCtr holds; next cycle Stall=0 -> 300.
REQ-040 SHALL cover: Halt at ProgCtr=50 -> DONE, Done=1, ProgCtr=50; Start in RUN ignored; Start in DONE -> ProgCtr=0, RUN, CycleCount cleared.
